// File: rtl/rv32im_muldiv_exu_if.sv
// Request/response bundle for the M-extension execute unit.
// The master drives operations and consumes results; the unit is the slave.
interface rv32im_muldiv_exu_if #(
  parameter int XLEN  = 32,
  parameter int TAG_W = 5
);
  logic             in_valid_i;
  logic             in_ready_o;
  logic [2:0]       op_i;
  logic [XLEN-1:0]  rs1_i;
  logic [XLEN-1:0]  rs2_i;
  logic [TAG_W-1:0] tag_i;
  logic             flush_i;
  logic             out_valid_o;
  logic             out_ready_i;
  logic [XLEN-1:0]  data_o;
  logic [TAG_W-1:0] tag_o;

  modport master (
    output in_valid_i, op_i, rs1_i, rs2_i, tag_i, flush_i, out_ready_i,
    input  in_ready_o, out_valid_o, data_o, tag_o
  );

  modport slave (
    input  in_valid_i, op_i, rs1_i, rs2_i, tag_i, flush_i, out_ready_i,
    output in_ready_o, out_valid_o, data_o, tag_o
  );
endinterface

// File: rtl/rv32im_muldiv_exu.sv
// Iterative RV32M multiply/divide unit: shift-add multiplier, restoring divider,
// sign fix-up on magnitudes, valid/ready handshakes and flush.
module rv32im_muldiv_exu #(
  parameter int XLEN     = 32,
  parameter int MUL_STEP = 1,
  parameter int TAG_W    = 5
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  rv32im_muldiv_exu_if.slave    io
);

  localparam int CNT_W = $clog2(XLEN + 1);

  typedef enum logic [1:0] {IDLE, BUSY, FIXUP, DONE} state_e;
  typedef enum logic [2:0] {
    OP_MUL, OP_MULH, OP_MULHSU, OP_MULHU, OP_DIV, OP_DIVU, OP_REM, OP_REMU
  } op_e;

  state_e              state_q, state_d;
  op_e                 op_q, op_d;
  logic [TAG_W-1:0]    tag_q, tag_d, tag_out_q, tag_out_d;
  logic                a_neg_q, a_neg_d, b_neg_q, b_neg_d;
  logic [XLEN-1:0]     b_mag_q, b_mag_d;
  logic [XLEN-1:0]     quo_q, quo_d, rem_q, rem_d;
  logic [XLEN-1:0]     data_q, data_d;
  logic [2*XLEN-1:0]   mcand_q, mcand_d, acc_q, acc_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;

  op_e                 op_in;
  logic                a_neg_in, b_neg_in, div_zero, div_ovf;
  logic [XLEN-1:0]     a_mag_in, b_mag_in;
  logic [2*XLEN-1:0]   pp, prod_s;
  logic [XLEN:0]       rem_shift, rem_diff;
  logic [XLEN-1:0]     quo_s, rem_s;

  assign op_in    = op_e'(io.op_i);
  assign a_neg_in = (op_in inside {OP_MULH, OP_MULHSU, OP_DIV, OP_REM}) && io.rs1_i[XLEN-1];
  assign b_neg_in = (op_in inside {OP_MULH, OP_DIV, OP_REM}) && io.rs2_i[XLEN-1];
  assign a_mag_in = a_neg_in ? -io.rs1_i : io.rs1_i;
  assign b_mag_in = b_neg_in ? -io.rs2_i : io.rs2_i;
  assign div_zero = (io.rs2_i == '0);
  assign div_ovf  = (op_in inside {OP_DIV, OP_REM}) && (io.rs2_i == '1) &&
                    (io.rs1_i == {1'b1, {(XLEN-1){1'b0}}});

  // Restoring step: the top bit of the widened difference is the borrow.
  assign rem_shift = {rem_q, quo_q[XLEN-1]};
  assign rem_diff  = rem_shift - {1'b0, b_mag_q};

  assign prod_s = (a_neg_q ^ b_neg_q) ? -acc_q : acc_q;
  assign quo_s  = (a_neg_q ^ b_neg_q) ? -quo_q : quo_q;
  assign rem_s  = a_neg_q ? -rem_q : rem_q;

  always_comb begin
    // NOTE: every _d defaults to its _q first so no path through the case infers a latch.
    state_d   = state_q;
    op_d      = op_q;
    tag_d     = tag_q;
    tag_out_d = tag_out_q;
    a_neg_d   = a_neg_q;
    b_neg_d   = b_neg_q;
    b_mag_d   = b_mag_q;
    quo_d     = quo_q;
    rem_d     = rem_q;
    data_d    = data_q;
    mcand_d   = mcand_q;
    acc_d     = acc_q;
    cnt_d     = cnt_q;

    pp = '0;
    for (int i = 0; i < MUL_STEP; i++) begin
      if (b_mag_q[i]) pp = pp + (mcand_q << i);
    end

    unique case (state_q)
      IDLE: begin
        if (io.in_valid_i) begin
          op_d    = op_in;
          tag_d   = io.tag_i;
          a_neg_d = a_neg_in;
          b_neg_d = b_neg_in;
          b_mag_d = b_mag_in;
          mcand_d = {{XLEN{1'b0}}, a_mag_in};
          acc_d   = '0;
          rem_d   = '0;
          quo_d   = a_mag_in;
          cnt_d   = io.op_i[2] ? CNT_W'(XLEN) : CNT_W'(XLEN / MUL_STEP);
          state_d = BUSY;
          if (io.op_i[2] && (div_zero || div_ovf)) begin
            // op_i[1] selects REM*; both special cases resolve without iterating.
            if (div_zero) data_d = io.op_i[1] ? io.rs1_i : '1;
            else          data_d = io.op_i[1] ? '0 : io.rs1_i;
            tag_out_d = io.tag_i;
            state_d   = DONE;
          end
        end
      end
      BUSY: begin
        if (op_q[2]) begin
          rem_d = rem_diff[XLEN] ? rem_shift[XLEN-1:0] : rem_diff[XLEN-1:0];
          quo_d = {quo_q[XLEN-2:0], ~rem_diff[XLEN]};
        end else begin
          acc_d   = acc_q + pp;
          mcand_d = mcand_q << MUL_STEP;
          b_mag_d = b_mag_q >> MUL_STEP;
        end
        cnt_d = cnt_q - 1'b1;
        if (cnt_q == CNT_W'(1)) state_d = FIXUP;
      end
      FIXUP: begin
        unique case (op_q)
          OP_MUL:                        data_d = prod_s[XLEN-1:0];
          OP_MULH, OP_MULHSU, OP_MULHU:  data_d = prod_s[2*XLEN-1:XLEN];
          OP_DIV, OP_DIVU:               data_d = quo_s;
          default:                       data_d = rem_s;
        endcase
        tag_out_d = tag_q;
        state_d   = DONE;
      end
      DONE: begin
        if (io.out_ready_i) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    if (io.flush_i) state_d = IDLE;
  end

  // NOTE: all datapath registers are plain flops, so every one of them is reset, not just the FSM.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q   <= IDLE;
      op_q      <= OP_MUL;
      tag_q     <= '0;
      tag_out_q <= '0;
      a_neg_q   <= 1'b0;
      b_neg_q   <= 1'b0;
      b_mag_q   <= '0;
      quo_q     <= '0;
      rem_q     <= '0;
      data_q    <= '0;
      mcand_q   <= '0;
      acc_q     <= '0;
      cnt_q     <= '0;
    end else begin
      // NOTE: non-blocking so every flop samples the pre-edge values of the others.
      state_q   <= state_d;
      op_q      <= op_d;
      tag_q     <= tag_d;
      tag_out_q <= tag_out_d;
      a_neg_q   <= a_neg_d;
      b_neg_q   <= b_neg_d;
      b_mag_q   <= b_mag_d;
      quo_q     <= quo_d;
      rem_q     <= rem_d;
      data_q    <= data_d;
      mcand_q   <= mcand_d;
      acc_q     <= acc_d;
      cnt_q     <= cnt_d;
    end
  end

  assign io.in_ready_o  = (state_q == IDLE);
  assign io.out_valid_o = (state_q == DONE);
  assign io.data_o      = data_q;
  assign io.tag_o       = tag_out_q;

endmodule

// File: tb/tb_rv32im_muldiv_exu.sv
// Self-checking bench: two units (MUL_STEP 1 and 4) run the same operations,
// compared against an arithmetic reference model of the RV32M rules.
module tb_rv32im_muldiv_exu;

  localparam logic [2:0] MUL = 3'd0, MULH = 3'd1, MULHSU = 3'd2, MULHU = 3'd3;
  localparam logic [2:0] DIV = 3'd4, DIVU = 3'd5, REM = 3'd6, REMU = 3'd7;

  logic clk;
  logic rst;
  int   checks = 0;
  int   errors = 0;

  rv32im_muldiv_exu_if #(.XLEN(32), .TAG_W(5)) bus1 ();
  rv32im_muldiv_exu_if #(.XLEN(32), .TAG_W(5)) bus4 ();

  rv32im_muldiv_exu #(.XLEN(32), .MUL_STEP(1), .TAG_W(5)) dut1 (
    .clk_i(clk), .rst_i(rst), .io(bus1.slave)
  );
  rv32im_muldiv_exu #(.XLEN(32), .MUL_STEP(4), .TAG_W(5)) dut4 (
    .clk_i(clk), .rst_i(rst), .io(bus4.slave)
  );

  assign bus4.in_valid_i  = bus1.in_valid_i;
  assign bus4.op_i        = bus1.op_i;
  assign bus4.rs1_i       = bus1.rs1_i;
  assign bus4.rs2_i       = bus1.rs2_i;
  assign bus4.tag_i       = bus1.tag_i;
  assign bus4.flush_i     = bus1.flush_i;
  assign bus4.out_ready_i = bus1.out_ready_i;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic bit is_special(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    return op[2] && ((b == 32'd0) || (!op[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF));
  endfunction

  function automatic logic [31:0] ref_res(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    longint      sa, sb, ub, q;
    logic [63:0] p;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    ub = longint'(b);
    p  = '0;
    q  = 0;
    case (op)
      MUL:    begin p = sa * sb; return p[31:0]; end
      MULH:   begin p = sa * sb; return p[63:32]; end
      MULHSU: begin p = sa * ub; return p[63:32]; end
      MULHU:  begin p = {32'd0, a} * {32'd0, b}; return p[63:32]; end
      DIV: begin
        if (b == 0) return 32'hFFFF_FFFF;
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'h8000_0000;
        q = sa / sb; return q[31:0];
      end
      DIVU: return (b == 0) ? 32'hFFFF_FFFF : a / b;
      REM: begin
        if (b == 0) return a;
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'd0;
        q = sa % sb; return q[31:0];
      end
      default: return (b == 0) ? a : a % b;
    endcase
  endfunction

  // Issue one operation with out_ready held high and check both units' result, tag and latency.
  task automatic run_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                        input logic [4:0] tag, input bit hold, input string name);
    logic [31:0] exp_d, d1, d4;
    logic [4:0]  t1, t4;
    int          exp1, exp4, lat1, lat4, e;
    bit          got1, got4, ready_bad;
    exp_d = ref_res(op, a, b);
    if (is_special(op, a, b)) begin exp1 = 0;  exp4 = 0;  end
    else if (op[2])           begin exp1 = 33; exp4 = 33; end
    else                      begin exp1 = 33; exp4 = 9;  end
    d1 = 'x; d4 = 'x; t1 = 'x; t4 = 'x; lat1 = -1; lat4 = -1;
    got1 = 0; got4 = 0; ready_bad = 0;
    @(negedge clk);
    bus1.out_ready_i = 1'b1;
    bus1.op_i = op; bus1.rs1_i = a; bus1.rs2_i = b; bus1.tag_i = tag;
    bus1.in_valid_i = 1'b1;
    @(negedge clk);
    e = 0;
    while (!(got1 && got4) && e <= 100) begin
      if (!got1) begin
        if (bus1.in_ready_o) ready_bad = 1;
        if (bus1.out_valid_o) begin got1 = 1; lat1 = e; d1 = bus1.data_o; t1 = bus1.tag_o; end
      end
      if (!got4 && bus4.out_valid_o) begin got4 = 1; lat4 = e; d4 = bus4.data_o; t4 = bus4.tag_o; end
      bus1.in_valid_i = hold && (e < 20);
      if (hold) begin
        bus1.op_i  = 3'($urandom_range(0, 7));
        bus1.rs1_i = $urandom;
        bus1.rs2_i = $urandom;
        bus1.tag_i = 5'($urandom_range(0, 31));
      end
      if (!(got1 && got4)) begin @(negedge clk); e++; end
    end
    bus1.in_valid_i = 1'b0;
    checks++; if (d1 !== exp_d) begin errors++; $display("FAIL %s data step1 got %h exp %h", name, d1, exp_d); end
    checks++; if (t1 !== tag)   begin errors++; $display("FAIL %s tag step1 got %0d exp %0d", name, t1, tag); end
    checks++; if (lat1 != exp1) begin errors++; $display("FAIL %s latency step1 got %0d exp %0d", name, lat1, exp1); end
    checks++; if (ready_bad !== 1'b0) begin errors++; $display("FAIL %s in_ready high while busy got 1 exp 0", name); end
    checks++; if (d4 !== exp_d) begin errors++; $display("FAIL %s data step4 got %h exp %h", name, d4, exp_d); end
    checks++; if (t4 !== tag)   begin errors++; $display("FAIL %s tag step4 got %0d exp %0d", name, t4, tag); end
    checks++; if (lat4 != exp4) begin errors++; $display("FAIL %s latency step4 got %0d exp %0d", name, lat4, exp4); end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    bus1.in_valid_i = 0; bus1.flush_i = 0; bus1.out_ready_i = 1;
    bus1.op_i = 0; bus1.rs1_i = 0; bus1.rs2_i = 0; bus1.tag_i = 0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    checks++;
    if ({bus1.in_ready_o, bus1.out_valid_o, bus1.data_o, bus1.tag_o} !== {1'b1, 1'b0, 32'd0, 5'd0}) begin
      errors++;
      $display("FAIL reset state got rdy=%b vld=%b data=%h tag=%0d exp rdy=1 vld=0 data=0 tag=0",
               bus1.in_ready_o, bus1.out_valid_o, bus1.data_o, bus1.tag_o);
    end
    checks++;
    if ({bus4.in_ready_o, bus4.out_valid_o, bus4.data_o, bus4.tag_o} !== {1'b1, 1'b0, 32'd0, 5'd0}) begin
      errors++;
      $display("FAIL reset state step4 got rdy=%b vld=%b data=%h exp rdy=1 vld=0 data=0",
               bus4.in_ready_o, bus4.out_valid_o, bus4.data_o);
    end
  endtask

  task automatic test_mul();
    run_op(MUL,    32'd7,          32'hFFFF_FFFD, 5'd3,  0, "mul_7_m3");
    run_op(MULHU,  32'hFFFF_FFFF,  32'hFFFF_FFFF, 5'd4,  0, "mulhu_max");
    run_op(MULH,   32'h8000_0000,  32'h8000_0000, 5'd5,  0, "mulh_min");
    run_op(MULHSU, 32'hFFFF_FFFF,  32'd2,         5'd6,  0, "mulhsu_m1_2");
  endtask

  task automatic test_div();
    run_op(DIV,  32'hFFFF_FFF9, 32'd2, 5'd7,  0, "div_m7_2");
    run_op(REM,  32'hFFFF_FFF9, 32'd2, 5'd8,  0, "rem_m7_2");
    run_op(DIVU, 32'd100,       32'd7, 5'd9,  0, "divu_100_7");
    run_op(REMU, 32'd100,       32'd7, 5'd10, 0, "remu_100_7");
  endtask

  task automatic test_special();
    run_op(DIVU, 32'd5,         32'd0,         5'd11, 0, "divu_by_zero");
    run_op(REM,  32'd5,         32'd0,         5'd12, 0, "rem_by_zero");
    run_op(DIV,  32'h8000_0000, 32'hFFFF_FFFF, 5'd13, 0, "div_overflow");
    run_op(REM,  32'h8000_0000, 32'hFFFF_FFFF, 5'd14, 0, "rem_overflow");
  endtask

  task automatic test_random();
    logic [2:0]  op;
    logic [31:0] a, b;
    for (int n = 0; n < 30; n++) begin
      op = 3'($urandom_range(0, 7));
      a  = $urandom;
      b  = $urandom;
      case ($urandom_range(0, 9))
        0: b = 32'd0;
        1: begin a = 32'h8000_0000; b = 32'hFFFF_FFFF; end
        2: b = $urandom_range(1, 15);
        3: a = $urandom_range(0, 15);
        4: b = -$urandom_range(1, 15);
        default: ;
      endcase
      run_op(op, a, b, 5'($urandom_range(0, 31)), 0, "random");
    end
  endtask

  // Inputs toggling during a divide must not disturb the result or be accepted.
  task automatic test_back_to_back();
    run_op(DIV,  32'd1000,      32'hFFFF_FFFD, 5'd15, 1, "busy_inputs_ignored");
    run_op(REMU, 32'hDEAD_BEEF, 32'd12345,     5'd16, 0, "back_to_back");
  endtask

  task automatic test_backpressure();
    logic [31:0] exp_d;
    int          e;
    exp_d = ref_res(DIVU, 32'd100, 32'd7);
    @(negedge clk);
    bus1.out_ready_i = 1'b0;
    bus1.op_i = DIVU; bus1.rs1_i = 32'd100; bus1.rs2_i = 32'd7; bus1.tag_i = 5'd21;
    bus1.in_valid_i = 1'b1;
    @(negedge clk);
    bus1.in_valid_i = 1'b0;
    e = 0;
    while (!bus1.out_valid_o && e < 100) begin @(negedge clk); e++; end
    checks++;
    if (bus1.out_valid_o !== 1'b1) begin errors++; $display("FAIL backpressure valid timeout got 0 exp 1"); end
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      checks++;
      if ({bus1.out_valid_o, bus1.in_ready_o, bus1.data_o, bus1.tag_o} !== {1'b1, 1'b0, exp_d, 5'd21}) begin
        errors++;
        $display("FAIL backpressure hold cycle %0d got vld=%b rdy=%b data=%h tag=%0d exp vld=1 rdy=0 data=%h tag=21",
                 k, bus1.out_valid_o, bus1.in_ready_o, bus1.data_o, bus1.tag_o, exp_d);
      end
    end
    bus1.out_ready_i = 1'b1;
    @(negedge clk);
    checks++;
    if ({bus1.in_ready_o, bus1.out_valid_o} !== 2'b10) begin
      errors++;
      $display("FAIL backpressure release got rdy=%b vld=%b exp rdy=1 vld=0", bus1.in_ready_o, bus1.out_valid_o);
    end
  endtask

  task automatic watch_quiet(input string name);
    bit seen;
    seen = 0;
    for (int k = 0; k < 45; k++) begin
      @(negedge clk);
      if (bus1.out_valid_o || bus4.out_valid_o) seen = 1;
    end
    checks++;
    if (seen !== 1'b0) begin errors++; $display("FAIL %s spurious out_valid got 1 exp 0", name); end
  endtask

  task automatic test_flush();
    // Flush beats accept in IDLE: a divide-by-zero would otherwise be DONE next cycle.
    @(negedge clk);
    bus1.op_i = DIVU; bus1.rs1_i = 32'd5; bus1.rs2_i = 32'd0; bus1.tag_i = 5'd1;
    bus1.in_valid_i = 1'b1; bus1.flush_i = 1'b1;
    @(negedge clk);
    bus1.in_valid_i = 1'b0; bus1.flush_i = 1'b0;
    checks++;
    if ({bus1.in_ready_o, bus1.out_valid_o} !== 2'b10) begin
      errors++;
      $display("FAIL flush_over_accept got rdy=%b vld=%b exp rdy=1 vld=0", bus1.in_ready_o, bus1.out_valid_o);
    end
    // Flush mid-BUSY.
    bus1.op_i = DIVU; bus1.rs1_i = $urandom; bus1.rs2_i = $urandom_range(1, 1000); bus1.tag_i = 5'd2;
    bus1.in_valid_i = 1'b1;
    @(negedge clk);
    bus1.in_valid_i = 1'b0;
    repeat (9) @(negedge clk);
    bus1.flush_i = 1'b1;
    @(negedge clk);
    bus1.flush_i = 1'b0;
    checks++;
    if ({bus1.in_ready_o, bus1.out_valid_o, bus4.in_ready_o, bus4.out_valid_o} !== 4'b1010) begin
      errors++;
      $display("FAIL flush_busy got rdy=%b vld=%b rdy4=%b vld4=%b exp 1 0 1 0",
               bus1.in_ready_o, bus1.out_valid_o, bus4.in_ready_o, bus4.out_valid_o);
    end
    watch_quiet("flush_busy");
    run_op(DIVU, 32'd9, 32'd3, 5'd17, 0, "after_flush");
  endtask

  task automatic test_reset_mid_busy();
    @(negedge clk);
    bus1.op_i = MULH; bus1.rs1_i = $urandom; bus1.rs2_i = $urandom; bus1.tag_i = 5'd22;
    bus1.in_valid_i = 1'b1;
    @(negedge clk);
    bus1.in_valid_i = 1'b0;
    repeat (5) @(negedge clk);
    rst = 1'b1;
    #1;
    checks++;
    if ({bus1.in_ready_o, bus1.out_valid_o, bus1.data_o, bus1.tag_o} !== {1'b1, 1'b0, 32'd0, 5'd0}) begin
      errors++;
      $display("FAIL async_reset got rdy=%b vld=%b data=%h tag=%0d exp rdy=1 vld=0 data=0 tag=0",
               bus1.in_ready_o, bus1.out_valid_o, bus1.data_o, bus1.tag_o);
    end
    @(negedge clk);
    rst = 1'b0;
    watch_quiet("reset_busy");
    run_op(DIVU, 32'd9, 32'd3, 5'd18, 0, "after_reset");
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_mul();
    test_div();
    test_special();
    test_back_to_back();
    test_backpressure();
    test_flush();
    test_reset_mid_busy();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
